// File: rtl/rotate_aligner.sv
// Stream realigner: drops the first cfg_off bits of each packet and repacks the
// remaining bits (little-endian) into W-bit words through a one-word funnel.
module rotate_aligner #(
  parameter int unsigned W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [$clog2(W)-1:0] cfg_off,
  input  logic                 in_vld,
  output logic                 in_rdy,
  input  logic [W-1:0]         in_dat,
  input  logic                 in_last,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [W-1:0]         out_dat,
  output logic                 out_last
);

  localparam int unsigned OW = $clog2(W);

  typedef enum logic [1:0] {IDLE, HOLD, FLUSH} state_t;

  state_t        state;
  logic [W-1:0]  hold;
  logic [OW-1:0] off_q;

  logic          ld_ok;
  logic          acc;
  logic [W-1:0]  mask;
  logic [W-1:0]  hold_rot;
  logic [W-1:0]  in_rot;
  logic [W-1:0]  merge;
  logic [W-1:0]  tail;

  function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input logic [OW-1:0] s);
    logic [2*W-1:0] d;
    d = {x, x} >> s;
    return d[W-1:0];
  endfunction

  assign ld_ok  = !out_vld || out_rdy;
  assign in_rdy = ld_ok && (state != FLUSH) && !rst;
  assign acc    = in_vld && in_rdy;

  // Both words rotated by the same amount; the mask selects held bits low, new bits high.
  assign mask     = {W{1'b1}} >> off_q;
  assign hold_rot = rotr(hold, off_q);
  assign in_rot   = rotr(in_dat, off_q);
  assign merge    = (hold_rot & mask) | (in_rot & ~mask);
  assign tail     = hold_rot & mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hold     <= '0;
      off_q    <= '0;
      out_vld  <= 1'b0;
      out_dat  <= '0;
      out_last <= 1'b0;
    end else begin
      if (out_vld && out_rdy) out_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (acc) begin
            off_q <= cfg_off;
            if (cfg_off == '0) begin
              out_vld  <= 1'b1;
              out_dat  <= in_dat;
              out_last <= in_last;
            end else begin
              hold  <= in_dat;
              state <= in_last ? FLUSH : HOLD;
            end
          end
        end
        HOLD: begin
          if (acc) begin
            out_vld  <= 1'b1;
            out_dat  <= merge;
            out_last <= 1'b0;
            hold     <= in_dat;
            state    <= in_last ? FLUSH : HOLD;
          end
        end
        FLUSH: begin
          if (ld_ok) begin
            out_vld  <= 1'b1;
            out_dat  <= tail;
            out_last <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rotate_aligner.sv
// Self-checking bench for rotate_aligner: directed cases plus randomized packets
// compared against a bit-stream model of the realignment.
module tb_rotate_aligner;

  localparam int unsigned W  = 32;
  localparam int unsigned OW = $clog2(W);

  logic          clk = 1'b0;
  logic          rst;
  logic [OW-1:0] cfg_off;
  logic          in_vld, in_rdy, in_last;
  logic [W-1:0]  in_dat;
  logic          out_vld, out_rdy, out_last;
  logic [W-1:0]  out_dat;

  int passed = 0;
  int total  = 0;
  int timeouts = 0;
  int stall_viol = 0;
  int cyc = 0;
  int first_cyc, last_cyc;
  int rdy_mode = 0;

  logic [W:0]   got_q[$];
  logic [W:0]   exp_q[$];
  logic [W-1:0] pkt[64];
  int           pkt_n;

  logic         prev_stall = 1'b0;
  logic [W:0]   prev_word;

  rotate_aligner #(.W(W)) dut (
    .clk(clk), .rst(rst), .cfg_off(cfg_off),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_dat(in_dat), .in_last(in_last),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_dat(out_dat), .out_last(out_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    out_rdy = (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output monitor: records transfers and flags any change while stalled.
  always @(negedge clk) begin
    if (!rst && prev_stall && (!out_vld || {out_last, out_dat} !== prev_word))
      stall_viol <= stall_viol + 1;
    prev_stall <= !rst && out_vld && !out_rdy;
    prev_word  <= {out_last, out_dat};
    if (!rst && out_vld && out_rdy) got_q.push_back({out_last, out_dat});
  end

  // Reference: word k of the output is stream bits [k*W+off .. k*W+off+W-1], zero past the end.
  function automatic logic [W-1:0] model_word(input int off, input int k);
    logic [W-1:0] r;
    int idx;
    r = '0;
    for (int b = 0; b < W; b++) begin
      idx = k * W + b + off;
      if (idx < pkt_n * W) r[b] = pkt[idx / W][idx % W];
    end
    return r;
  endfunction

  function automatic void build_exp(input int off);
    for (int k = 0; k < pkt_n; k++) exp_q.push_back({1'(k == pkt_n - 1), model_word(off, k)});
  endfunction

  task automatic wait_accept();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_rdy) begin
        @(posedge clk);
        #1;
        last_cyc = cyc;
        return;
      end
      n++;
      if (n > 500) begin
        timeouts++;
        @(posedge clk);
        #1;
        return;
      end
    end
  endtask

  task automatic send_packet(input int off, input int new_off);
    cfg_off = OW'(off);
    for (int i = 0; i < pkt_n; i++) begin
      in_vld  = 1'b1;
      in_dat  = pkt[i];
      in_last = (i == pkt_n - 1);
      wait_accept();
      if (i == 0) begin
        first_cyc = last_cyc;
        cfg_off   = OW'(new_off);
      end
    end
    in_vld  = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (got_q.size() < exp_q.size() && n < 1000) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (out_vld !== 1'b0) $display("FAIL reset_vld got=%b exp=0", out_vld); else passed++;
    total++; if (out_dat !== '0) $display("FAIL reset_dat got=%h exp=0", out_dat); else passed++;
    total++; if (out_last !== 1'b0) $display("FAIL reset_last got=%b exp=0", out_last); else passed++;
    total++; if (in_rdy !== 1'b0) $display("FAIL reset_rdy got=%b exp=0", in_rdy); else passed++;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_align();
    got_q.delete(); exp_q.delete();
    pkt[0] = 32'h33221100; pkt[1] = 32'h77665544; pkt_n = 2;
    send_packet(8, 8);
    drain();
    total++; if (got_q.size() !== 2) $display("FAIL align_count got=%0d exp=2", got_q.size()); else passed++;
    if (got_q.size() > 0) begin
      total++; if (got_q[0] !== {1'b0, 32'h44332211}) $display("FAIL align_w0 got=%h exp=044332211", got_q[0]); else passed++;
    end
    if (got_q.size() > 1) begin
      total++; if (got_q[1] !== {1'b1, 32'h00776655}) $display("FAIL align_w1 got=%h exp=100776655", got_q[1]); else passed++;
    end
  endtask

  task automatic test_pass_through();
    for (int i = 0; i < 4; i++) pkt[i] = $urandom;
    cfg_off = '0;
    in_vld = 1'b1; in_dat = pkt[0]; in_last = 1'b0;
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        total++; if (out_vld !== 1'b1) $display("FAIL pt_vld[%0d] got=%b exp=1", i - 1, out_vld); else passed++;
        total++; if (out_dat !== pkt[i-1]) $display("FAIL pt_dat[%0d] got=%h exp=%h", i - 1, out_dat, pkt[i-1]); else passed++;
        total++; if (out_last !== 1'(i == 4)) $display("FAIL pt_last[%0d] got=%b exp=%b", i - 1, out_last, i == 4); else passed++;
      end
      if (i < 4) begin
        total++; if (in_rdy !== 1'b1) $display("FAIL pt_rdy[%0d] got=%b exp=1", i, in_rdy); else passed++;
      end
      @(posedge clk);
      #1;
      if (i + 1 < 4) begin
        in_dat = pkt[i+1]; in_last = (i + 1 == 3);
      end else begin
        in_vld = 1'b0; in_last = 1'b0;
      end
    end
    drain();
  endtask

  task automatic test_single();
    cfg_off = 4;
    in_vld = 1'b1; in_dat = 32'hABCD1234; in_last = 1'b1;
    wait_accept();
    in_vld = 1'b0; in_last = 1'b0;
    @(negedge clk);
    total++; if (in_rdy !== 1'b0) $display("FAIL single_flush_rdy got=%b exp=0", in_rdy); else passed++;
    total++; if (out_vld !== 1'b0) $display("FAIL single_early_vld got=%b exp=0", out_vld); else passed++;
    @(negedge clk);
    total++; if (in_rdy !== 1'b1) $display("FAIL single_after_rdy got=%b exp=1", in_rdy); else passed++;
    total++; if ({out_vld, out_last, out_dat} !== {2'b11, 32'h0ABCD123})
      $display("FAIL single_word got=%b/%b/%h exp=1/1/0abcd123", out_vld, out_last, out_dat); else passed++;
    drain();
  endtask

  task automatic test_backpressure();
    got_q.delete(); exp_q.delete();
    stall_viol = 0;
    pkt_n = 16;
    for (int i = 0; i < pkt_n; i++) pkt[i] = $urandom;
    build_exp(12);
    rdy_mode = 1;
    send_packet(12, 12);
    drain();
    rdy_mode = 0;
    drain();
    total++; if (stall_viol !== 0) $display("FAIL bp_stable got=%0d exp=0 changes", stall_viol); else passed++;
    total++; if (got_q.size() !== exp_q.size()) $display("FAIL bp_count got=%0d exp=%0d", got_q.size(), exp_q.size()); else passed++;
    foreach (exp_q[k]) if (k < got_q.size()) begin
      total++; if (got_q[k] !== exp_q[k]) $display("FAIL bp_word[%0d] got=%h exp=%h", k, got_q[k], exp_q[k]); else passed++;
    end
  endtask

  task automatic test_off_latch();
    int a_last;
    got_q.delete(); exp_q.delete();
    pkt_n = 5;
    for (int i = 0; i < pkt_n; i++) pkt[i] = $urandom;
    build_exp(5);
    send_packet(5, 20);
    a_last = last_cyc;
    pkt_n = 3;
    for (int i = 0; i < pkt_n; i++) pkt[i] = $urandom;
    build_exp(20);
    send_packet(20, 20);
    total++; if (first_cyc - a_last !== 2) $display("FAIL latch_gap got=%0d exp=2 cycles", first_cyc - a_last); else passed++;
    drain();
    total++; if (got_q.size() !== exp_q.size()) $display("FAIL latch_count got=%0d exp=%0d", got_q.size(), exp_q.size()); else passed++;
    foreach (exp_q[k]) if (k < got_q.size()) begin
      total++; if (got_q[k] !== exp_q[k]) $display("FAIL latch_word[%0d] got=%h exp=%h", k, got_q[k], exp_q[k]); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    cfg_off = 8;
    in_vld = 1'b1; in_dat = 32'h11111111; in_last = 1'b0;
    wait_accept();
    in_dat = 32'h22222222;
    wait_accept();
    in_vld = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    total++; if (out_vld !== 1'b1) $display("FAIL rmid_pre_vld got=%b exp=1", out_vld); else passed++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    total++; if ({out_vld, out_last, out_dat} !== '0)
      $display("FAIL rmid_cleared got=%b/%b/%h exp=0/0/0", out_vld, out_last, out_dat); else passed++;
    got_q.delete(); exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    total++; if (got_q.size() !== 0) $display("FAIL rmid_no_partial got=%0d exp=0", got_q.size()); else passed++;
    pkt_n = 3;
    for (int i = 0; i < pkt_n; i++) pkt[i] = $urandom;
    build_exp(8);
    send_packet(8, 8);
    drain();
    total++; if (got_q.size() !== exp_q.size()) $display("FAIL rmid_count got=%0d exp=%0d", got_q.size(), exp_q.size()); else passed++;
    foreach (exp_q[k]) if (k < got_q.size()) begin
      total++; if (got_q[k] !== exp_q[k]) $display("FAIL rmid_word[%0d] got=%h exp=%h", k, got_q[k], exp_q[k]); else passed++;
    end
  endtask

  initial begin
    rst = 1'b1; cfg_off = '0; in_vld = 1'b0; in_dat = '0; in_last = 1'b0;
    pkt_n = 0; first_cyc = 0; last_cyc = 0;
    test_reset();
    test_align();
    test_pass_through();
    test_single();
    test_backpressure();
    test_off_latch();
    test_reset_mid();
    total++; if (timeouts !== 0) $display("FAIL accept_timeouts got=%0d exp=0", timeouts); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
